// File: rtl/man_row_prefetch.sv
// Sprite row prefetcher: fetches the next scanline's 3 sprite words during hblank into a
// double-buffered line store and presents the word covering the current pixel combinationally.
module man_row_prefetch #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int ROM_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  ManX,
    input  logic [9:0]  ManY,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] man_data,
    output logic [9:0]  ManX_q,
    output logic [9:0]  ManY_q,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT = 3'(ROM_LATENCY);

    state_t            state;
    logic [2:0]        cyc;
    logic [4:0]        fetch_r;
    logic [5:0]        fetch_base;
    logic [2:0][31:0]  shadow_w;
    logic              shadow_valid;
    logic [4:0]        shadow_r;
    logic [5:0]        shadow_base;
    logic [2:0][31:0]  act_w;
    logic              act_valid;
    logic [4:0]        act_r;
    logic [5:0]        act_base;

    logic [9:0] ny;
    logic       hit;
    logic [4:0] r_next;
    logic [5:0] base_next;
    logic       trigger;
    logic       swap;

    always_comb begin
        ny        = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
        hit       = (ny >= ManY_q) && (ny < ManY_q + 10'd20);
        r_next    = 5'(ny - ManY_q);
        base_next = 6'((9'({r_next, 4'b0}) + 9'({r_next, 2'b0})) >> 3);
        trigger   = (DrawX == 10'(H_ACTIVE));
        swap      = (DrawX == 10'(H_TOTAL - 1));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ManX_q <= '0;
            ManY_q <= '0;
        end else if (DrawY == 10'(V_ACTIVE) && DrawX == 10'd0) begin
            ManX_q <= ManX;
            ManY_q <= ManY;
        end
    end

    // Capture slots are counted from the first issued address, so the same
    // counter works whether captures overlap ISSUE (short latency) or not.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cyc          <= '0;
            rom_addr     <= '0;
            busy         <= 1'b0;
            fetch_r      <= '0;
            fetch_base   <= '0;
            shadow_w     <= '0;
            shadow_valid <= 1'b0;
            shadow_r     <= '0;
            shadow_base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        shadow_valid <= 1'b0;
                        cyc          <= '0;
                        if (hit) begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            rom_addr   <= base_next;
                            fetch_r    <= r_next;
                            fetch_base <= base_next;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    cyc <= cyc + 3'd1;
                    if (state == ISSUE && cyc < 3'd2)
                        rom_addr <= rom_addr + 6'd1;
                    if (state == ISSUE && cyc == 3'd2)
                        state <= WAIT;
                    if (cyc == LAT)
                        shadow_w[0] <= rom_data;
                    if (cyc == LAT + 3'd1)
                        shadow_w[1] <= rom_data;
                    if (cyc == LAT + 3'd2) begin
                        shadow_w[2]  <= rom_data;
                        shadow_valid <= 1'b1;
                        shadow_r     <= fetch_r;
                        shadow_base  <= fetch_base;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (swap)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            act_w     <= '0;
            act_valid <= 1'b0;
            act_r     <= '0;
            act_base  <= '0;
        end else if (swap) begin
            act_w     <= shadow_w;
            act_valid <= shadow_valid;
            act_r     <= shadow_r;
            act_base  <= shadow_base;
        end
    end

    logic       inx;
    logic [8:0] lin;
    logic [1:0] widx;

    always_comb begin
        inx      = ({1'b0, DrawX} >= {1'b0, ManX_q}) && ({1'b0, DrawX} < {1'b0, ManX_q} + 11'd20);
        lin      = 9'(5'(DrawX - ManX_q)) + 9'({act_r, 4'b0}) + 9'({act_r, 2'b0});
        widx     = 2'((lin >> 3) - 9'(act_base));
        man_data = '0;
        if (act_valid && inx) begin
            case (widx)
                2'd0:    man_data = act_w[0];
                2'd1:    man_data = act_w[1];
                2'd2:    man_data = act_w[2];
                default: man_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_man_row_prefetch.sv
// Directed bench for man_row_prefetch: two instances (ROM latency 2 and 4) share the
// video timing inputs; each has its own delayed ROM model.
module tb_man_row_prefetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, ManX, ManY;
    logic [5:0]  rom_addr, rom_addr4;
    logic [31:0] rom_data, rom_data4;
    logic [31:0] man_data, man_data4;
    logic [9:0]  ManX_q, ManY_q, ManX_q4, ManY_q4;
    logic        busy, busy4;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    man_row_prefetch #(.ROM_LATENCY(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .ManX(ManX), .ManY(ManY),
        .rom_addr(rom_addr), .rom_data(rom_data), .man_data(man_data),
        .ManX_q(ManX_q), .ManY_q(ManY_q), .busy(busy)
    );

    man_row_prefetch #(.ROM_LATENCY(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .ManX(ManX), .ManY(ManY),
        .rom_addr(rom_addr4), .rom_data(rom_data4), .man_data(man_data4),
        .ManX_q(ManX_q4), .ManY_q(ManY_q4), .busy(busy4)
    );

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return {10'h2A5, a, 10'h15A, a};
    endfunction

    logic [5:0] p2 [2];
    logic [5:0] p4 [4];
    always @(posedge Clk) begin
        p2[0] <= rom_addr;
        p2[1] <= p2[0];
        p4[0] <= rom_addr4;
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign rom_data  = rom_word(p2[1]);
    assign rom_data4 = rom_word(p4[3]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Runs the blanking portion of line y (columns 640..799), checking addresses and busy time.
    task automatic hblank(input logic [9:0] y, input bit hit, input logic [5:0] base, input string tag);
        int b2, b4;
        logic [5:0] ea;
        b2 = 0;
        b4 = 0;
        DrawY = y;
        for (int x = 640; x < 800; x++) begin
            DrawX = 10'(x);
            #1;
            if (busy)  b2++;
            if (busy4) b4++;
            if (x >= 641 && x <= 643) begin
                ea = hit ? base + 6'(x - 641) : base;
                chk({tag, "_addr"},  32'(rom_addr),  32'(ea));
                chk({tag, "_addr4"}, 32'(rom_addr4), 32'(ea));
            end
            tick();
        end
        chk({tag, "_busy_cycles"},  32'(b2), hit ? 32'd5 : 32'd0);
        chk({tag, "_busy_cycles4"}, 32'(b4), hit ? 32'd7 : 32'd0);
    endtask

    task automatic disp(input logic [9:0] y, input logic [9:0] x, input logic [31:0] exp, input string tag);
        DrawY = y;
        DrawX = x;
        #1;
        chk(tag, man_data, exp);
        chk({tag, "_l4"}, man_data4, exp);
        tick();
    endtask

    task automatic latch_pos();
        DrawY = 10'd480;
        DrawX = 10'd0;
        tick();
        DrawX = 10'd1;
    endtask

    initial begin
        Reset = 1'b1;
        DrawX = 10'd0;
        DrawY = 10'd0;
        ManX  = 10'd0;
        ManY  = 10'd0;
        tick();
        tick();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_man_data", man_data, 32'd0);
        chk("rst_manx_q",   32'(ManX_q), 32'd0);
        chk("rst_many_q",   32'(ManY_q), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        Reset = 1'b0;
        tick();

        // Position latch and its insensitivity to other cycles
        ManX = 10'd200;
        ManY = 10'd100;
        latch_pos();
        chk("latch_x", 32'(ManX_q), 32'd200);
        chk("latch_y", 32'(ManY_q), 32'd100);
        ManX = 10'd5;
        ManY = 10'd7;
        DrawY = 10'd480;
        DrawX = 10'd1;
        tick();
        DrawY = 10'd481;
        DrawX = 10'd0;
        tick();
        chk("nolatch_x", 32'(ManX_q), 32'd200);
        chk("nolatch_y", 32'(ManY_q4), 32'd100);

        // Row 0 of the sprite on line 100
        hblank(10'd99, 1'b1, 6'd0, "r0");
        disp(10'd100, 10'd199, 32'd0,        "r0_x199");
        disp(10'd100, 10'd200, rom_word(0),  "r0_x200");
        disp(10'd100, 10'd207, rom_word(0),  "r0_x207");
        disp(10'd100, 10'd208, rom_word(1),  "r0_x208");
        disp(10'd100, 10'd215, rom_word(1),  "r0_x215");
        disp(10'd100, 10'd216, rom_word(2),  "r0_x216");
        disp(10'd100, 10'd219, rom_word(2),  "r0_x219");
        disp(10'd100, 10'd220, 32'd0,        "r0_x220");

        // Odd row: starts mid-word
        hblank(10'd100, 1'b1, 6'd2, "r1");
        disp(10'd101, 10'd200, rom_word(2),  "r1_x200");
        disp(10'd101, 10'd211, rom_word(3),  "r1_x211");
        disp(10'd101, 10'd212, rom_word(4),  "r1_x212");

        // Last sprite row, then first row past the sprite
        hblank(10'd118, 1'b1, 6'd47, "r19");
        disp(10'd119, 10'd200, rom_word(47), "r19_x200");
        disp(10'd119, 10'd219, rom_word(49), "r19_x219");
        hblank(10'd119, 1'b0, 6'd49, "r20");
        disp(10'd120, 10'd200, 32'd0,        "r20_x200");

        // Live ManY change only takes effect at the next latch
        ManX = 10'd200;
        ManY = 10'd300;
        DrawY = 10'd200;
        tick();
        hblank(10'd299, 1'b0, 6'd49, "mv_pre");
        disp(10'd300, 10'd200, 32'd0,        "mv_pre_x200");
        latch_pos();
        chk("mv_latch_y", 32'(ManY_q), 32'd300);
        hblank(10'd299, 1'b1, 6'd0, "mv_post");
        disp(10'd300, 10'd200, rom_word(0),  "mv_post_x200");
        disp(10'd300, 10'd219, rom_word(2),  "mv_post_x219");

        // Frame wrap: last line prefetches line 0
        ManX = 10'd50;
        ManY = 10'd0;
        latch_pos();
        hblank(10'd524, 1'b1, 6'd0, "wrap");
        disp(10'd0, 10'd49, 32'd0,           "wrap_x49");
        disp(10'd0, 10'd50, rom_word(0),     "wrap_x50");
        disp(10'd0, 10'd57, rom_word(0),     "wrap_x57");
        disp(10'd0, 10'd58, rom_word(1),     "wrap_x58");

        // Reset in the middle of an issue burst
        DrawY = 10'd524;
        for (int x = 640; x < 800; x++) begin
            DrawX = 10'(x);
            #1;
            if (x == 642) begin
                chk("midrst_busy_before", 32'(busy), 32'd1);
                Reset = 1'b1;
                #1;
                chk("midrst_busy",   32'(busy),      32'd0);
                chk("midrst_busy4",  32'(busy4),     32'd0);
                chk("midrst_addr",   32'(rom_addr),  32'd0);
                chk("midrst_addr4",  32'(rom_addr4), 32'd0);
            end
            tick();
            Reset = 1'b0;
        end
        disp(10'd0, 10'd0,  32'd0, "midrst_x0");
        disp(10'd0, 10'd10, 32'd0, "midrst_x10");
        disp(10'd0, 10'd50, 32'd0, "midrst_x50");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
